apb_uart_bridge: RTL and testbench
==================================

APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 32; APB data width, 8..32, multiple of 8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8; TX and RX FIFO depth in bytes, power of 2, 2..64.
REQ-003 SHALL have parameter ADDR_W, default 4; number of decoded paddr bits.
REQ-004 SHALL have a single clock; reset is asynchronous and active-high (clk, rst).
REQ-005 Ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-006 Ports: psel  in  1  slave select; penable  in  1  access phase; pwrite  in  1  1=write; paddr  in  ADDR_W  byte address.
REQ-007 Ports: pwdata  in  DATA_W  write data; prdata  out  DATA_W  read data; pready  out  1  transfer complete; pslverr  out  1  error response.
REQ-008 Ports: tx_start  out  1  one-cycle start pulse; tx_data  out  8  byte to send; tx_done  in  1  one-cycle pulse, byte sent; tx_busy  in  1  transmitter active.
REQ-009 Ports: rx_data  in  8  received byte; rx_done  in  1  one-cycle pulse, rx_data valid; rx_err  in  1  frame/parity error, qualified by rx_done.
REQ-010 Ports: tx_en  out  1  transmitter enable; rx_en  out  1  receiver enable; irq  out  1  level interrupt.

Function
REQ-011 Register map (paddr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 reserved; paddr[1:0] ignored.
REQ-012 APB FSM states IDLE, SETUP, ACCESS; psel&!penable -> SETUP; SETUP -> ACCESS; ACCESS asserts pready for exactly one cycle -> IDLE (or SETUP if psel held and penable low).
REQ-013 Zero wait states: every transfer completes in 2 cycles; register side effects occur in the ACCESS cycle only.
REQ-014 DATA write pushes pwdata[7:0] into TX FIFO; DATA read returns RX FIFO head in prdata[7:0], zero-extended, and pops it.
REQ-015 STATUS read: bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 rx_overrun (sticky), bit5 rx_error (sticky), bits[11:8] tx_count, bits[19:16] rx_count (counts truncated to field width when FIFO_DEPTH > 15), others 0.
REQ-016 STATUS write of 1 to bit4/bit5 clears that flag; other bits ignored.
REQ-017 CTRL (read/write): bit0 tx_en, bit1 rx_en, bit2 irq_tx_empty_en, bit3 irq_rx_avail_en, bit4 tx_flush, bit5 rx_flush; flush bits self-clear and empty the FIFO in the ACCESS cycle.
REQ-018 tx_en, rx_en outputs SHALL equal CTRL bit0, bit1.
REQ-019 TX FSM states TX_IDLE, TX_START, TX_WAIT; TX_IDLE -> TX_START when tx_en & !tx_empty & !tx_busy.
REQ-020 TX_START: drive tx_data = TX head, tx_start=1 for one cycle -> TX_WAIT; tx_data SHALL stay stable until tx_done.
REQ-021 TX_WAIT: on tx_done pop TX FIFO -> TX_IDLE; back-to-back bytes need minimum 1 idle cycle between tx_done and next tx_start.
REQ-022 tx_en deasserted mid-byte: current byte completes, no new tx_start issued.
REQ-023 rx_done with rx_en=1 pushes rx_data; rx_err with rx_done sets rx_error and still pushes the byte.
REQ-024 rx_done with RX FIFO full: byte discarded, rx_overrun set, FIFO contents unchanged; rx_done with rx_en=0 ignored.
REQ-025 Simultaneous APB pop and rx_done push on full RX FIFO: both succeed, no overrun; simultaneous push and pop on TX FIFO: both succeed, count unchanged.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-027 DATA write to full TX FIFO: data dropped; DATA read of empty RX FIFO: prdata=0, no pop.
REQ-028 irq = (irq_tx_empty_en & tx_empty) | (irq_rx_avail_en & !rx_empty), registered, 1-cycle latency.
REQ-029 prdata SHALL be 0 outside the ACCESS cycle of a read.

Reset
REQ-030 rst SHALL immediately set: APB FSM IDLE, TX FSM TX_IDLE, both FIFOs empty, CTRL=0, sticky flags 0.
REQ-031 Outputs during/after rst: prdata=0, pready=0, pslverr=0, tx_start=0, tx_data=0, tx_en=0, rx_en=0, irq=0.
REQ-032 rst mid-byte abandons the byte; no tx_start for ≥1 cycle after release.

Configuration
REQ-033 Macro APB_UART_PSLVERR_EN defined: pslverr=1 with pready on DATA write to full TX FIFO, DATA read of empty RX FIFO, or access to reserved address; no side effects on errored transfer.
REQ-034 Macro APB_UART_PSLVERR_EN undefined: pslverr tied 0; REQ-027 behaviour applies silently.

Verification
REQ-035 Reset, write CTRL=0x3, write DATA 0x41,0x42 -> two tx_start pulses, tx_data 0x41 then 0x42, each held until tx_done.
REQ-036 FIFO_DEPTH=8, tx_busy=1, write 9 bytes -> STATUS tx_full=1, tx_count=8, 9th dropped (pslverr=1 only with macro).
REQ-037 Nine rx_done pulses rx_data 0x10..0x18 -> rx_overrun=1; eight reads return 0x10..0x17, then rx_empty=1.
REQ-038 rx_done with rx_err=1, rx_data=0x55 -> rx_error=1, read DATA=0x55; write STATUS 0x20 -> rx_error=0.
REQ-039 CTRL irq_rx_avail_en=1, one rx_done -> irq=1 next cycle; read DATA -> irq=0.
REQ-040 Assert rst during TX_WAIT -> all outputs zero in same cycle, FIFOs empty after release.

Source files
------------

// File: rtl/apb_uart_bridge.sv
// apb_uart_bridge -- APB slave front-end for a byte-oriented UART core.
// Holds TX/RX byte FIFOs, STATUS and CTRL registers, drives the transmitter
// start handshake and raises a level interrupt.
// Optional build macro: APB_UART_PSLVERR_EN (error responses on DATA write to a
// full TX FIFO, DATA read of an empty RX FIFO and reserved-address accesses).
module apb_uart_bridge #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_err,
    output logic              tx_en,
    output logic              rx_en,
    output logic              irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_WAIT} tx_state_t;

    apb_state_t        apb_q;
    tx_state_t         tx_q;
    logic              pready_q;
    logic              pslverr_q;
    logic [DATA_W-1:0] prdata_q;
    logic              rd_pop_q;
    logic              xfer_err_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
    logic              irq_q;
    logic [3:0]        ctrl_q;
    logic              rx_ovr_q;
    logic              rx_error_q;

    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
    logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q;

    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic [1:0]  reg_sel;
    logic        setup_err;
    logic        access_ok;
    logic        tx_push, tx_pop, tx_flush;
    logic        rx_push_req, rx_push, rx_pop, rx_flush, rx_ovr_set;
    logic        stat_wr;
    logic [31:0] status_w;
    logic [31:0] rd_word;
    logic        unused_bits;

    assign reg_sel  = paddr[3:2];
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);

`ifdef APB_UART_PSLVERR_EN
    assign setup_err = (reg_sel == REG_RSVD)
                     || (reg_sel == REG_DATA && pwrite && tx_full)
                     || (reg_sel == REG_DATA && !pwrite && rx_empty);
`else
    assign setup_err = 1'b0;
`endif

    // Register side effects are applied only at the end of a non-errored access phase
    assign access_ok   = pready_q && psel && penable && !xfer_err_q;
    assign stat_wr     = access_ok && pwrite && (reg_sel == REG_STATUS);
    assign tx_flush    = access_ok && pwrite && (reg_sel == REG_CTRL) && pwdata[4];
    assign rx_flush    = access_ok && pwrite && (reg_sel == REG_CTRL) && pwdata[5];
    assign tx_pop      = (tx_q == TX_WAIT) && tx_done && !tx_empty && !tx_flush;
    assign tx_push     = access_ok && pwrite && (reg_sel == REG_DATA) && (!tx_full || tx_pop);
    // Pop only if the head was actually returned in the setup-phase capture
    assign rx_pop      = access_ok && !pwrite && (reg_sel == REG_DATA) && rd_pop_q;
    assign rx_push_req = rx_done && ctrl_q[1];
    assign rx_push     = rx_push_req && (!rx_full || rx_pop) && !rx_flush;
    assign rx_ovr_set  = rx_push_req && rx_full && !rx_pop && !rx_flush;

    // Read word for the addressed register
    always_comb begin
        status_w        = '0;
        status_w[0]     = tx_empty;
        status_w[1]     = tx_full;
        status_w[2]     = rx_empty;
        status_w[3]     = rx_full;
        status_w[4]     = rx_ovr_q;
        status_w[5]     = rx_error_q;
        status_w[11:8]  = 4'(tx_cnt_q);
        status_w[19:16] = 4'(rx_cnt_q);
        rd_word         = '0;
        case (reg_sel)
            REG_DATA:   rd_word = rx_empty ? '0 : {24'b0, rx_mem[rx_rd_q]};
            REG_STATUS: rd_word = status_w;
            REG_CTRL:   rd_word = {28'b0, ctrl_q};
            default:    rd_word = '0;
        endcase
    end

    // APB handshake; apb_q names the bus phase sampled at the previous edge, so
    // pready/prdata/pslverr registered there are valid for the whole access phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apb_q      <= IDLE;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            rd_pop_q   <= 1'b0;
            xfer_err_q <= 1'b0;
        end else begin
            case (apb_q)
                SETUP: begin
                    apb_q      <= ACCESS;
                    pready_q   <= 1'b0;
                    pslverr_q  <= 1'b0;
                    prdata_q   <= '0;
                    rd_pop_q   <= 1'b0;
                    xfer_err_q <= 1'b0;
                end
                default: begin
                    if (psel && !penable) begin
                        apb_q      <= SETUP;
                        pready_q   <= 1'b1;
                        pslverr_q  <= setup_err;
                        prdata_q   <= (!pwrite && !setup_err) ? rd_word[DATA_W-1:0] : '0;
                        rd_pop_q   <= !pwrite && (reg_sel == REG_DATA) && !rx_empty;
                        xfer_err_q <= setup_err;
                    end else begin
                        apb_q      <= IDLE;
                        pready_q   <= 1'b0;
                        pslverr_q  <= 1'b0;
                        prdata_q   <= '0;
                        rd_pop_q   <= 1'b0;
                        xfer_err_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // CTRL register and sticky RX flags (a new event wins over a same-cycle clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            rx_ovr_q   <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            if (access_ok && pwrite && (reg_sel == REG_CTRL))
                ctrl_q <= pwdata[3:0];
            if (rx_ovr_set)
                rx_ovr_q <= 1'b1;
            else if (stat_wr && pwdata[4])
                rx_ovr_q <= 1'b0;
            if (rx_push_req && rx_err)
                rx_error_q <= 1'b1;
            else if (stat_wr && pwdata[5])
                rx_error_q <= 1'b0;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else if (tx_flush) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
            tx_cnt_q <= tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else if (rx_flush) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            rx_cnt_q <= rx_cnt_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
        end
    end

    // FIFO storage (contents need no reset; occupancy qualifies every read)
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= pwdata[7:0];
        if (rx_push) rx_mem[rx_wr_q] <= rx_data;
    end

    // Transmit sequencer: one start pulse per byte, data held until tx_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q       <= TX_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            case (tx_q)
                TX_IDLE: begin
                    tx_start_q <= 1'b0;
                    if (ctrl_q[0] && !tx_empty && !tx_busy && !tx_flush) begin
                        tx_q       <= TX_START;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= tx_mem[tx_rd_q];
                    end
                end
                TX_START: begin
                    tx_q       <= TX_WAIT;
                    tx_start_q <= 1'b0;
                end
                TX_WAIT: begin
                    tx_start_q <= 1'b0;
                    if (tx_done) tx_q <= TX_IDLE;
                end
                default: begin
                    tx_q       <= TX_IDLE;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= (ctrl_q[2] && tx_empty) || (ctrl_q[3] && !rx_empty);
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = ctrl_q[0];
    assign rx_en    = ctrl_q[1];
    assign irq      = irq_q;

    assign unused_bits = ^{paddr, pwdata, rd_word};

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Directed bench for apb_uart_bridge with TX/RX byte scoreboards.
module tb_apb_uart_bridge;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_W     = 4;

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_STAT = 4'h4;
    localparam logic [3:0] A_CTRL = 4'h8;
    localparam logic [3:0] A_RSVD = 4'hC;
`ifdef APB_UART_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [DATA_W-1:0] prdata;
    logic              pready, pslverr, tx_start, tx_en, rx_en, irq;
    logic [7:0]        tx_data;
    logic              tx_done = 1'b0, tx_busy = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rx_done = 1'b0, rx_err = 1'b0;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb_tx[$];
    logic [7:0] sb_rx[$];

    apb_uart_bridge #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_done(rx_done), .rx_err(rx_err),
        .tx_en(tx_en), .rx_en(rx_en), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            input logic rx_in_access, input logic [7:0] rx_byte,
                            output logic [31:0] rdata, output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wr ? wdata : '0;
        @(posedge clk); #1;
        penable = 1'b1;
        if (rx_in_access) begin
            rx_done = 1'b1;
            rx_data = rx_byte;
        end
        @(negedge clk);
        check("pready_access", pready, 1'b1);
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; rx_done = 1'b0;
    endtask

    task automatic apb_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                             input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, addr, data, 1'b0, 8'h00, rd, err);
        check({tag, "_err"}, err, exp_err);
    endtask

    task automatic apb_read(input string tag, input logic [3:0] addr, input logic [31:0] exp_data,
                            input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, addr, '0, 1'b0, 8'h00, rd, err);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, err, exp_err);
        @(negedge clk);
        check({tag, "_idle"}, {pready, prdata}, '0);
    endtask

    // DATA write: byte joins the TX scoreboard unless it is expected to be dropped
    task automatic tx_write(input logic [7:0] b, input logic dropped);
        if (!dropped) sb_tx.push_back(b);
        apb_write("tx_write", A_DATA, {24'h0, b}, dropped & ERR_EN);
    endtask

    // DATA read: expected value is the RX scoreboard head, or 0 when empty
    task automatic rx_read(input string tag);
        if (sb_rx.size() > 0) apb_read(tag, A_DATA, {24'h0, sb_rx.pop_front()}, 1'b0);
        else                  apb_read(tag, A_DATA, 32'h0, ERR_EN);
    endtask

    task automatic rx_pulse(input logic [7:0] b, input logic e);
        @(posedge clk); #1;
        rx_done = 1'b1; rx_data = b; rx_err = e;
        @(posedge clk); #1;
        rx_done = 1'b0; rx_err = 1'b0;
    endtask

    // Wait (bounded) for a start pulse and compare its byte with the TX scoreboard
    task automatic tx_expect(output logic [7:0] got, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_start && n < 30);
        check("tx_start_seen", tx_start, 1'b1);
        got = tx_data;
        if (sb_tx.size() > 0) check("tx_data", tx_data, sb_tx.pop_front());
        else                  check("tx_sb_empty", 1'b0, 1'b1);
        tx_busy = 1'b1;
    endtask

    task automatic tx_finish(input logic [7:0] b, input int hold);
        logic stable;
        stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (tx_data !== b || tx_start !== 1'b0) stable = 1'b0;
        end
        check("tx_data_hold", stable, 1'b1);
        @(posedge clk); #1;
        tx_done = 1'b1; tx_busy = 1'b0;
        @(posedge clk); #1;
        tx_done = 1'b0;
    endtask

    task automatic no_tx_start(input string tag, input int n);
        logic quiet;
        quiet = 1'b1;
        repeat (n) begin
            @(negedge clk);
            if (tx_start !== 1'b0) quiet = 1'b0;
        end
        check(tag, quiet, 1'b1);
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] rd;
        logic        err;
        int          n;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {prdata, pready, pslverr, tx_start, tx_data, tx_en, rx_en, irq}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        apb_read("status_reset", A_STAT, 32'h0000_0005, 1'b0);
        apb_read("ctrl_reset", A_CTRL, 32'h0, 1'b0);

        // Enable and send two bytes
        apb_write("ctrl_en", A_CTRL, 32'h3, 1'b0);
        @(negedge clk);
        check("tx_rx_en", {tx_en, rx_en}, 2'b11);
        tx_write(8'h41, 1'b0);
        tx_expect(b, n);
        tx_write(8'h42, 1'b0);
        tx_finish(8'h41, 4);
        tx_expect(b, n);
        check("tx_gap_min", (n >= 2), 1'b1);
        tx_finish(8'h42, 3);
        apb_read("status_tx_drained", A_STAT, 32'h0000_0005, 1'b0);

        // tx_en dropped mid-byte: current byte completes, next is held back
        tx_write(8'h77, 1'b0);
        tx_expect(b, n);
        apb_write("ctrl_txoff", A_CTRL, 32'h2, 1'b0);
        tx_write(8'h78, 1'b0);
        tx_finish(8'h77, 2);
        no_tx_start("tx_held_when_disabled", 8);
        apb_read("status_one_pending", A_STAT, 32'h0000_0104, 1'b0);
        apb_write("ctrl_txon", A_CTRL, 32'h3, 1'b0);
        tx_expect(b, n);
        tx_finish(8'h78, 2);

        // Fill TX FIFO while transmitter is busy; ninth byte dropped
        tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) tx_write(8'hA0 + 8'(i), (i == 8));
        apb_read("status_tx_full", A_STAT, 32'h0000_0806, 1'b0);
        no_tx_start("tx_busy_blocks", 3);
        apb_write("ctrl_tx_flush", A_CTRL, 32'h13, 1'b0);
        sb_tx.delete();
        apb_read("status_after_flush", A_STAT, 32'h0000_0005, 1'b0);
        apb_read("ctrl_flush_selfclear", A_CTRL, 32'h3, 1'b0);
        tx_busy = 1'b0;
        no_tx_start("tx_empty_idle", 4);

        // Nine receptions into an eight-deep RX FIFO
        for (int i = 0; i < 9; i++) begin
            if (sb_rx.size() < FIFO_DEPTH) sb_rx.push_back(8'h10 + 8'(i));
            rx_pulse(8'h10 + 8'(i), 1'b0);
        end
        apb_read("status_rx_overrun", A_STAT, 32'h0008_0019, 1'b0);
        for (int i = 0; i < 8; i++) rx_read("rx_drain");
        apb_read("status_rx_empty", A_STAT, 32'h0000_0015, 1'b0);
        rx_read("rx_read_empty");
        apb_write("status_clr_ovr", A_STAT, 32'h10, 1'b0);
        apb_read("status_ovr_cleared", A_STAT, 32'h0000_0005, 1'b0);

        // Pop and push in the same cycle on a full RX FIFO
        for (int i = 0; i < 8; i++) begin
            sb_rx.push_back(8'h20 + 8'(i));
            rx_pulse(8'h20 + 8'(i), 1'b0);
        end
        apb_read("status_rx_full", A_STAT, 32'h0008_0009, 1'b0);
        b = sb_rx.pop_front();
        sb_rx.push_back(8'h28);
        apb_xfer(1'b0, A_DATA, '0, 1'b1, 8'h28, rd, err);
        check("rx_simul_data", rd, {24'h0, b});
        apb_read("status_simul_no_ovr", A_STAT, 32'h0008_0009, 1'b0);
        for (int i = 0; i < 8; i++) rx_read("rx_drain2");
        apb_read("status_rx_drained", A_STAT, 32'h0000_0005, 1'b0);

        // Frame error: byte still stored, sticky flag cleared by STATUS write
        sb_rx.push_back(8'h55);
        rx_pulse(8'h55, 1'b1);
        apb_read("status_rx_error", A_STAT, 32'h0001_0021, 1'b0);
        rx_read("rx_err_byte");
        apb_write("status_clr_err", A_STAT, 32'h20, 1'b0);
        apb_read("status_err_cleared", A_STAT, 32'h0000_0005, 1'b0);

        // Interrupt sources
        apb_write("ctrl_irq_rx", A_CTRL, 32'hB, 1'b0);
        @(negedge clk);
        check("irq_idle", irq, 1'b0);
        sb_rx.push_back(8'h66);
        rx_pulse(8'h66, 1'b0);
        @(negedge clk);
        check("irq_latency", irq, 1'b0);
        @(negedge clk);
        check("irq_rx_avail", irq, 1'b1);
        rx_read("rx_irq_byte");
        @(negedge clk);
        check("irq_rx_cleared", irq, 1'b0);
        apb_write("ctrl_irq_tx", A_CTRL, 32'h7, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", irq, 1'b1);
        apb_write("ctrl_irq_off", A_CTRL, 32'h3, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_off", irq, 1'b0);

        // Reserved address
        apb_read("rsvd_read", A_RSVD, 32'h0, ERR_EN);

        // Reset while a byte is in flight
        apb_write("ctrl_pre_rst", A_CTRL, 32'hB, 1'b0);
        tx_write(8'h99, 1'b0);
        tx_expect(b, n);
        rx_pulse(8'h12, 1'b0);
        repeat (2) @(negedge clk);
        check("irq_before_rst", irq, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {prdata, pready, pslverr, tx_start, tx_data, tx_en, rx_en, irq}, '0);
        @(negedge clk);
        check("rst_held_outputs", {prdata, pready, pslverr, tx_start, tx_data, tx_en, rx_en, irq}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        tx_busy = 1'b0;
        sb_tx.delete();
        sb_rx.delete();
        no_tx_start("tx_quiet_after_rst", 4);
        apb_read("status_after_rst", A_STAT, 32'h0000_0005, 1'b0);
        apb_read("ctrl_after_rst", A_CTRL, 32'h0, 1'b0);
        rx_read("rx_empty_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
